// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
// Run controller and monitor that sits beside the multicycle datapath.
// It gates the datapath clock enable from a start request and counts enabled
// cycles and instruction fetches. A run ends in HALTED when the PC is seen
// unchanged across HALT_REPEAT further fetch entries (the jump-to-self idiom),
// or in TIMEOUT when the cycle limit is reached. If both happen on the same
// edge, halt takes priority.
//
// Optional build macro: CPU_RUN_MONITOR_WRCNT_EN
//   When defined, the wr_count output is added. It counts RUN cycles that
//   have reg_write high.
//   When undefined, there is no wr_count port and reg_write is ignored.
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int DATA_W      = 16,
    parameter int STATE_W     = 5,
    parameter int FETCH_STATE = 0,
    parameter int CYCLE_W     = 32,
    parameter int MAX_CYCLES  = 100000,
    parameter int HALT_REPEAT = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [DATA_W-1:0]  pc,
    input  logic [STATE_W-1:0] current_state,
    input  logic [DATA_W-1:0]  ir,
    input  logic               reg_write,
    output logic               cpu_en,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [CYCLE_W-1:0] instr_count,
    output logic [DATA_W-1:0]  halt_pc,
    output logic [DATA_W-1:0]  halt_ir
`ifdef CPU_RUN_MONITOR_WRCNT_EN
    ,
    output logic [CYCLE_W-1:0] wr_count
`endif
);

    localparam int REP_W = $clog2(HALT_REPEAT + 1);

    localparam logic [STATE_W-1:0] FETCH_CODE = STATE_W'(FETCH_STATE);
    // The bitwise inverse is guaranteed to differ from the fetch code, so the
    // first fetch after a start always counts as a fetch entry.
    localparam logic [STATE_W-1:0] NOT_FETCH  = ~FETCH_CODE;
    localparam logic [CYCLE_W-1:0] CNT_ONE    = CYCLE_W'(1);
    localparam logic [CYCLE_W-1:0] CNT_ZERO   = CYCLE_W'(0);
    localparam logic [CYCLE_W-1:0] LIMIT_M1   = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [REP_W-1:0]   REP_ONE    = REP_W'(1);
    localparam logic [REP_W-1:0]   REP_ZERO   = REP_W'(0);
    localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(HALT_REPEAT - 1);
    localparam logic [DATA_W-1:0]  DATA_ZERO  = DATA_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } fsm_e;

    fsm_e               fsm_r;
    logic [STATE_W-1:0] prev_state_r;
    logic               first_fetch_r;
    logic [DATA_W-1:0]  last_fetch_pc_r;
    logic [REP_W-1:0]   repeat_r;

    logic               fetch_entry_s;
    logic               same_pc_s;
    logic               halt_hit_s;
    logic               limit_hit_s;

`ifndef CPU_RUN_MONITOR_WRCNT_EN
    logic               unused_reg_write_s;
    assign unused_reg_write_s = reg_write;
`endif

    // Decode fetch entry, repeated-PC halt and cycle-limit conditions for this edge.
    always_comb begin
        fetch_entry_s = 1'b0;
        same_pc_s     = 1'b0;
        halt_hit_s    = 1'b0;
        limit_hit_s   = 1'b0;
        if (fsm_r == ST_RUN) begin
            fetch_entry_s = (current_state == FETCH_CODE) && (prev_state_r != FETCH_CODE);
            limit_hit_s   = (cycle_count == LIMIT_M1);
        end else begin
            fetch_entry_s = 1'b0;
            limit_hit_s   = 1'b0;
        end
        if (fetch_entry_s && !first_fetch_r && (pc == last_fetch_pc_r)) begin
            same_pc_s  = 1'b1;
            halt_hit_s = (repeat_r == REP_LAST);
        end else begin
            same_pc_s  = 1'b0;
            halt_hit_s = 1'b0;
        end
    end

    // Run-control FSM together with all registered outputs and counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fsm_r           <= ST_IDLE;
            prev_state_r    <= {STATE_W{1'b0}};
            first_fetch_r   <= 1'b1;
            last_fetch_pc_r <= DATA_ZERO;
            repeat_r        <= REP_ZERO;
            cpu_en          <= 1'b0;
            running         <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            cycle_count     <= CNT_ZERO;
            instr_count     <= CNT_ZERO;
            halt_pc         <= DATA_ZERO;
            halt_ir         <= DATA_ZERO;
`ifdef CPU_RUN_MONITOR_WRCNT_EN
            wr_count        <= CNT_ZERO;
`endif
        end else begin
            case (fsm_r)
                ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                    if (start) begin
                        fsm_r           <= ST_RUN;
                        prev_state_r    <= NOT_FETCH;
                        first_fetch_r   <= 1'b1;
                        last_fetch_pc_r <= DATA_ZERO;
                        repeat_r        <= REP_ZERO;
                        cpu_en          <= 1'b1;
                        running         <= 1'b1;
                        done            <= 1'b0;
                        timeout         <= 1'b0;
                        cycle_count     <= CNT_ZERO;
                        instr_count     <= CNT_ZERO;
                        halt_pc         <= DATA_ZERO;
                        halt_ir         <= DATA_ZERO;
`ifdef CPU_RUN_MONITOR_WRCNT_EN
                        wr_count        <= CNT_ZERO;
`endif
                    end
                end
                ST_RUN: begin
                    // The counter stops at MAX_CYCLES because the run leaves
                    // RUN on the edge that reaches it.
                    cycle_count  <= cycle_count + CNT_ONE;
                    prev_state_r <= current_state;
`ifdef CPU_RUN_MONITOR_WRCNT_EN
                    if (reg_write) begin
                        wr_count <= wr_count + CNT_ONE;
                    end
`endif
                    if (fetch_entry_s) begin
                        instr_count <= instr_count + CNT_ONE;
                        if (first_fetch_r) begin
                            last_fetch_pc_r <= pc;
                            first_fetch_r   <= 1'b0;
                        end else if (same_pc_s) begin
                            repeat_r <= repeat_r + REP_ONE;
                        end else begin
                            repeat_r        <= REP_ZERO;
                            last_fetch_pc_r <= pc;
                        end
                    end
                    // Halt has priority over a timeout on the same edge.
                    if (halt_hit_s) begin
                        fsm_r   <= ST_HALTED;
                        done    <= 1'b1;
                        cpu_en  <= 1'b0;
                        running <= 1'b0;
                        halt_pc <= pc;
                        halt_ir <= ir;
                    end else if (limit_hit_s) begin
                        fsm_r   <= ST_TIMEOUT;
                        timeout <= 1'b1;
                        cpu_en  <= 1'b0;
                        running <= 1'b0;
                    end
                end
                default: begin
                    fsm_r   <= ST_IDLE;
                    cpu_en  <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cpu_run_monitor.
// Three instances share one stimulus:
//   u0: MAX_CYCLES=40     -- straight-line halt, then timeout
//   u1: MAX_CYCLES=21     -- halt and timeout land on the same edge
//   u2: MAX_CYCLES=100000 -- long run that is reset mid-flight at cycle 50
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [4:0]  current_state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        reg_write;

    logic        cpu_en_w   [3];
    logic        running_w  [3];
    logic        done_w     [3];
    logic        timeout_w  [3];
    logic [31:0] cycle_w    [3];
    logic [31:0] instr_w    [3];
    logic [15:0] halt_pc_w  [3];
    logic [15:0] halt_ir_w  [3];
`ifdef CPU_RUN_MONITOR_WRCNT_EN
    logic [31:0] wr_count_w [3];
`endif

    int n_total;
    int n_pass;

    typedef struct {
        logic        start;
        logic [4:0]  st;
        logic [15:0] pc;
        logic        run;
        logic        done;
        logic [31:0] cyc;
        logic [31:0] ins;
    } vec_t;

    vec_t tbl [23];

    cpu_run_monitor #(.DATA_W(16), .STATE_W(5), .FETCH_STATE(0), .CYCLE_W(32),
                      .MAX_CYCLES(40), .HALT_REPEAT(2)) u0 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .pc(pc),
        .current_state(current_state), .ir(ir), .reg_write(reg_write),
        .cpu_en(cpu_en_w[0]), .running(running_w[0]), .done(done_w[0]),
        .timeout(timeout_w[0]), .cycle_count(cycle_w[0]), .instr_count(instr_w[0]),
        .halt_pc(halt_pc_w[0]), .halt_ir(halt_ir_w[0])
`ifdef CPU_RUN_MONITOR_WRCNT_EN
        , .wr_count(wr_count_w[0])
`endif
    );

    cpu_run_monitor #(.DATA_W(16), .STATE_W(5), .FETCH_STATE(0), .CYCLE_W(32),
                      .MAX_CYCLES(21), .HALT_REPEAT(2)) u1 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .pc(pc),
        .current_state(current_state), .ir(ir), .reg_write(reg_write),
        .cpu_en(cpu_en_w[1]), .running(running_w[1]), .done(done_w[1]),
        .timeout(timeout_w[1]), .cycle_count(cycle_w[1]), .instr_count(instr_w[1]),
        .halt_pc(halt_pc_w[1]), .halt_ir(halt_ir_w[1])
`ifdef CPU_RUN_MONITOR_WRCNT_EN
        , .wr_count(wr_count_w[1])
`endif
    );

    cpu_run_monitor #(.DATA_W(16), .STATE_W(5), .FETCH_STATE(0), .CYCLE_W(32),
                      .MAX_CYCLES(100000), .HALT_REPEAT(2)) u2 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .pc(pc),
        .current_state(current_state), .ir(ir), .reg_write(reg_write),
        .cpu_en(cpu_en_w[2]), .running(running_w[2]), .done(done_w[2]),
        .timeout(timeout_w[2]), .cycle_count(cycle_w[2]), .instr_count(instr_w[2]),
        .halt_pc(halt_pc_w[2]), .halt_ir(halt_ir_w[2])
`ifdef CPU_RUN_MONITOR_WRCNT_EN
        , .wr_count(wr_count_w[2])
`endif
    );

    // 100 MHz free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act !== exp_v) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_inst(input int i, input string tag, input logic exp_run,
                              input logic exp_done, input logic exp_to,
                              input logic [31:0] exp_cyc, input logic [31:0] exp_ins);
        chk($sformatf("%s/u%0d/cpu_en", tag, i),  {31'd0, cpu_en_w[i]},  {31'd0, exp_run});
        chk($sformatf("%s/u%0d/running", tag, i), {31'd0, running_w[i]}, {31'd0, exp_run});
        chk($sformatf("%s/u%0d/done", tag, i),    {31'd0, done_w[i]},    {31'd0, exp_done});
        chk($sformatf("%s/u%0d/timeout", tag, i), {31'd0, timeout_w[i]}, {31'd0, exp_to});
        chk($sformatf("%s/u%0d/cycles", tag, i),  cycle_w[i], exp_cyc);
        chk($sformatf("%s/u%0d/instrs", tag, i),  instr_w[i], exp_ins);
    endtask

    task automatic check_halt(input int i, input string tag,
                              input logic [15:0] exp_pc, input logic [15:0] exp_ir);
        chk($sformatf("%s/u%0d/halt_pc", tag, i), {16'd0, halt_pc_w[i]}, {16'd0, exp_pc});
        chk($sformatf("%s/u%0d/halt_ir", tag, i), {16'd0, halt_ir_w[i]}, {16'd0, exp_ir});
    endtask

    // Apply one cycle of stimulus on the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input logic s, input logic [4:0] st, input logic [15:0] p);
        @(negedge CLK);
        start         = s;
        current_state = st;
        pc            = p;
        ir            = 16'hB000 | p;
        reg_write     = (st != 5'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // Straight-line program: fetch every 4 cycles at PC 0,2,4,6, then PC
        // stays at 6. The second repeated fetch of 6 lands on RUN edge 21.
        //           start  st    pc     run   done  cyc    ins
        tbl[0]  = '{1'b1, 5'd3, 16'd0, 1'b1, 1'b0, 32'd0,  32'd0};
        tbl[1]  = '{1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 32'd1,  32'd1};
        tbl[2]  = '{1'b0, 5'd1, 16'd0, 1'b1, 1'b0, 32'd2,  32'd1};
        tbl[3]  = '{1'b0, 5'd2, 16'd0, 1'b1, 1'b0, 32'd3,  32'd1};
        tbl[4]  = '{1'b0, 5'd3, 16'd0, 1'b1, 1'b0, 32'd4,  32'd1};
        tbl[5]  = '{1'b0, 5'd0, 16'd2, 1'b1, 1'b0, 32'd5,  32'd2};
        tbl[6]  = '{1'b0, 5'd1, 16'd2, 1'b1, 1'b0, 32'd6,  32'd2};
        tbl[7]  = '{1'b0, 5'd2, 16'd2, 1'b1, 1'b0, 32'd7,  32'd2};
        tbl[8]  = '{1'b0, 5'd3, 16'd2, 1'b1, 1'b0, 32'd8,  32'd2};
        tbl[9]  = '{1'b0, 5'd0, 16'd4, 1'b1, 1'b0, 32'd9,  32'd3};
        tbl[10] = '{1'b0, 5'd1, 16'd4, 1'b1, 1'b0, 32'd10, 32'd3};
        tbl[11] = '{1'b0, 5'd2, 16'd4, 1'b1, 1'b0, 32'd11, 32'd3};
        tbl[12] = '{1'b0, 5'd3, 16'd4, 1'b1, 1'b0, 32'd12, 32'd3};
        tbl[13] = '{1'b0, 5'd0, 16'd6, 1'b1, 1'b0, 32'd13, 32'd4};
        tbl[14] = '{1'b0, 5'd1, 16'd6, 1'b1, 1'b0, 32'd14, 32'd4};
        tbl[15] = '{1'b0, 5'd2, 16'd6, 1'b1, 1'b0, 32'd15, 32'd4};
        tbl[16] = '{1'b0, 5'd3, 16'd6, 1'b1, 1'b0, 32'd16, 32'd4};
        tbl[17] = '{1'b0, 5'd0, 16'd6, 1'b1, 1'b0, 32'd17, 32'd5};
        tbl[18] = '{1'b0, 5'd1, 16'd6, 1'b1, 1'b0, 32'd18, 32'd5};
        tbl[19] = '{1'b0, 5'd2, 16'd6, 1'b1, 1'b0, 32'd19, 32'd5};
        tbl[20] = '{1'b0, 5'd3, 16'd6, 1'b1, 1'b0, 32'd20, 32'd5};
        tbl[21] = '{1'b0, 5'd0, 16'd6, 1'b0, 1'b1, 32'd21, 32'd6};
        tbl[22] = '{1'b0, 5'd1, 16'd6, 1'b0, 1'b1, 32'd21, 32'd6};

        // Reset state: create a real falling edge on RST_N, then stay idle.
        RST_N         = 1'b1;
        start         = 1'b0;
        current_state = 5'd3;
        pc            = 16'd0;
        ir            = 16'd0;
        reg_write     = 1'b0;
        #2 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_inst(i, "reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            check_halt(i, "reset", 16'd0, 16'd0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b0, 5'd0, 16'd0);
        drive(1'b0, 5'd0, 16'd4);
        for (int i = 0; i < 3; i++) begin
            check_inst(i, "idle", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        // Straight-line run; on u1 the halt coincides with the cycle limit.
        for (int k = 0; k < 23; k++) begin
            drive(tbl[k].start, tbl[k].st, tbl[k].pc);
            for (int i = 0; i < 3; i++) begin
                check_inst(i, $sformatf("line[%0d]", k), tbl[k].run, tbl[k].done,
                           1'b0, tbl[k].cyc, tbl[k].ins);
            end
        end
        for (int i = 0; i < 3; i++) begin
            check_halt(i, "line", 16'd6, 16'hB006);
        end
`ifdef CPU_RUN_MONITOR_WRCNT_EN
        // reg_write is high in states 1..3: 15 of the 21 RUN edges.
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("line/u%0d/wr_count", i), wr_count_w[i], 32'd15);
        end
`endif

        // Restart from HALTED: the next edge clears everything and enters RUN.
        drive(1'b1, 5'd1, 16'd6);
        for (int i = 0; i < 3; i++) begin
            check_inst(i, "restart", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            check_halt(i, "restart", 16'd0, 16'd0);
`ifdef CPU_RUN_MONITOR_WRCNT_EN
            chk($sformatf("restart/u%0d/wr_count", i), wr_count_w[i], 32'd0);
`endif
        end

        // PC advances on every fetch, so only the cycle limit can end a run.
        // A start pulse on RUN edge 10 must be ignored.
        for (int k = 1; k <= 50; k++) begin
            drive(k == 10, 5'((k - 1) % 4), 16'(2 * ((k - 1) / 4)));
            if (k == 10) begin
                for (int i = 0; i < 3; i++) begin
                    check_inst(i, "ignore_start", 1'b1, 1'b0, 1'b0, 32'd10, 32'd3);
                end
            end
            if (k == 11) begin
                chk("ignore_start/u0/cycles_next", cycle_w[0], 32'd11);
            end
            if (k == 21) begin
                check_inst(1, "timeout21", 1'b0, 1'b0, 1'b1, 32'd21, 32'd6);
                check_halt(1, "timeout21", 16'd0, 16'd0);
                check_inst(0, "run21", 1'b1, 1'b0, 1'b0, 32'd21, 32'd6);
            end
            if (k == 39) begin
                check_inst(0, "pre_timeout", 1'b1, 1'b0, 1'b0, 32'd39, 32'd10);
            end
            if (k == 40) begin
                check_inst(0, "timeout40", 1'b0, 1'b0, 1'b1, 32'd40, 32'd10);
                check_halt(0, "timeout40", 16'd0, 16'd0);
            end
            if (k == 45) begin
                check_inst(0, "hold40", 1'b0, 1'b0, 1'b1, 32'd40, 32'd10);
                check_inst(1, "hold21", 1'b0, 1'b0, 1'b1, 32'd21, 32'd6);
            end
            if (k == 50) begin
                check_inst(2, "pre_reset", 1'b1, 1'b0, 1'b0, 32'd50, 32'd13);
            end
        end

        // Asynchronous reset between clock edges while u2 is running.
        #2;
        RST_N = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_inst(i, "async_reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 5'((k + 1) % 4), 16'd8);
        end
        for (int i = 0; i < 3; i++) begin
            check_inst(i, "post_reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
